// File: rtl/grid_pkg.sv
// Shared definitions for the grid data bus: unit counts, destination index ranges and FSM encodings.
// The CHECK encoding is only reached when the design is built with GRID_CHECK_EN.
package grid_pkg;

    localparam int NUM_CORES = 6;
    localparam int NUM_L3    = 4;
    localparam int NUM_RAM   = 2;
    localparam int NUM_DEST  = NUM_CORES + NUM_L3 + NUM_RAM;

    localparam int DEST_W         = 4;
    localparam int BYTES_PER_WORD = 4;

    // Destination index ranges, in the same order the round-robin visits them.
    localparam int CORE_FIRST = 0;
    localparam int CORE_LAST  = NUM_CORES - 1;
    localparam int L3_FIRST   = NUM_CORES;
    localparam int L3_LAST    = NUM_CORES + NUM_L3 - 1;
    localparam int RAM_FIRST  = NUM_CORES + NUM_L3;
    localparam int RAM_LAST   = NUM_DEST - 1;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_CHECK   = 2'd1,
        ST_HOLD    = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        DC_CORE = 2'd0,
        DC_L3   = 2'd1,
        DC_RAM  = 2'd2
    } dest_class_e;

    function automatic dest_class_e dest_class(input logic [DEST_W-1:0] idx);
        dest_class_e cls;
        cls = DC_CORE;
        if (int'(idx) >= RAM_FIRST) begin
            cls = DC_RAM;
        end else if (int'(idx) >= L3_FIRST) begin
            cls = DC_L3;
        end
        return cls;
    endfunction

endpackage

// File: rtl/grid_fold8.sv
// 32->8 XOR fold: the checksum of a grid bus word. Shared with the outbound path so the
// checksum is defined in exactly one place.
module grid_fold8 (
    input  logic [31:0] word_in,
    output logic [7:0]  fold_out
);

    logic [7:0] partial [0:3];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fold
            if (gi == 0) begin : g_first
                assign partial[gi] = word_in[7:0];
            end else begin : g_rest
                assign partial[gi] = partial[gi-1] ^ word_in[8*gi +: 8];
            end
        end
    endgenerate

    assign fold_out = partial[3];

endmodule

// File: rtl/grid_word_dispatch.sv
// Rebuilds big-endian 32-bit words from the inbound byte stream and hands them round-robin to
// the grid units. Define GRID_CHECK_EN for 5-byte frames with a fold8 check byte and error stats.
module grid_word_dispatch #(
    parameter int NUM_DEST  = grid_pkg::NUM_DEST,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    output logic [31:0]          word_out,
    output logic                 word_valid,
    input  logic                 word_ready,
    output logic [3:0]           dest_sel,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    import grid_pkg::*;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] asm_q, asm_d;
    logic [31:0] word_q, word_d;
    logic [3:0]  dest_q, dest_d;
    logic        byte_ready_q, byte_ready_d;
    logic        word_valid_q, word_valid_d;

    logic        byte_xfer;
    logic        word_xfer;
    logic [31:0] asm_shift;

`ifdef GRID_CHECK_EN
    logic                 err_pulse_q, err_pulse_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [7:0]           fold;

    grid_fold8 u_fold (
        .word_in  (asm_q),
        .fold_out (fold)
    );
`endif

    assign byte_xfer = byte_valid && byte_ready_q;
    assign word_xfer = word_valid_q && word_ready;
    // Shifting left keeps the first byte of the frame in [31:24] once all four have arrived.
    assign asm_shift = {asm_q[23:0], byte_in};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        asm_d        = asm_q;
        word_d       = word_q;
        dest_d       = dest_q;
        byte_ready_d = byte_ready_q;
        word_valid_d = word_valid_q;
`ifdef GRID_CHECK_EN
        err_pulse_d  = 1'b0;
        err_cnt_d    = err_cnt_q;
`endif

        case (state_q)
            ST_COLLECT: begin
                if (byte_xfer) begin
                    asm_d = asm_shift;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
`ifdef GRID_CHECK_EN
                        state_d = ST_CHECK;
`else
                        state_d      = ST_HOLD;
                        word_d       = asm_shift;
                        byte_ready_d = 1'b0;
                        word_valid_d = 1'b1;
`endif
                    end
                end
            end
`ifdef GRID_CHECK_EN
            ST_CHECK: begin
                if (byte_xfer) begin
                    if (byte_in == fold) begin
                        state_d      = ST_HOLD;
                        word_d       = asm_q;
                        byte_ready_d = 1'b0;
                        word_valid_d = 1'b1;
                    end else begin
                        // Dropped frame: word_out and dest_sel keep their previous values.
                        state_d     = ST_COLLECT;
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
                            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                        end
                    end
                end
            end
`endif
            ST_HOLD: begin
                // byte_ready stays low on the transfer edge, which forces the bubble cycle.
                if (word_xfer) begin
                    state_d      = ST_COLLECT;
                    word_valid_d = 1'b0;
                    byte_ready_d = 1'b1;
                    dest_d       = (dest_q == 4'(NUM_DEST - 1)) ? 4'd0 : dest_q + 4'd1;
                end
            end
            default: begin
                state_d      = ST_COLLECT;
                cnt_d        = 2'd0;
                byte_ready_d = 1'b1;
                word_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_COLLECT;
            cnt_q        <= 2'd0;
            asm_q        <= 32'd0;
            word_q       <= 32'd0;
            dest_q       <= 4'd0;
            byte_ready_q <= 1'b1;
            word_valid_q <= 1'b0;
`ifdef GRID_CHECK_EN
            err_pulse_q  <= 1'b0;
            err_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            asm_q        <= asm_d;
            word_q       <= word_d;
            dest_q       <= dest_d;
            byte_ready_q <= byte_ready_d;
            word_valid_q <= word_valid_d;
`ifdef GRID_CHECK_EN
            err_pulse_q  <= err_pulse_d;
            err_cnt_q    <= err_cnt_d;
`endif
        end
    end

    assign byte_ready = byte_ready_q;
    assign word_valid = word_valid_q;
    assign word_out   = word_q;
    assign dest_sel   = dest_q;

`ifdef GRID_CHECK_EN
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
`else
    assign err_pulse = 1'b0;
    assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_grid_word_dispatch.sv
// Self-checking bench for grid_word_dispatch: random frames against a queue-based reference
// model of word order, round-robin destinations and dropped-frame statistics.
module tb_grid_word_dispatch;

    localparam int NDEST = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic [3:0]  dest_sel;
    logic        err_pulse;
    logic [7:0]  err_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int          exp_dest = 0;
    int          exp_err = 0;
    int          exp_pulses = 0;
    logic [31:0] exp_w[$];
    int          exp_d[$];

    // Observed transfers.
    logic [31:0] obs_w[$];
    int          obs_d[$];
    int          err_seen = 0;

    grid_word_dispatch #(.NUM_DEST(12), .ERR_CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .dest_sel   (dest_sel),
        .err_pulse  (err_pulse),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (word_valid && word_ready) begin
                obs_w.push_back(word_out);
                obs_d.push_back(int'(dest_sel));
            end
            if (err_pulse) err_seen++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] fold_ref(input logic [31:0] w);
        logic [7:0] r;
        r = 8'd0;
        for (int i = 0; i < 4; i++) r = r ^ w[8*i +: 8];
        return r;
    endfunction

    task automatic push_model(input logic [31:0] w);
        exp_w.push_back(w);
        exp_d.push_back(exp_dest);
        exp_dest = (exp_dest + 1) % NDEST;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        @(negedge clk);
        while (!byte_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) begin
            total++;
            bad++;
            $display("FAIL send_byte_timeout got=byte_ready 0 want=1");
        end
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] w, input bit good);
        for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
`ifdef GRID_CHECK_EN
        if (good) begin
            send_byte(fold_ref(w));
            push_model(w);
        end else begin
            send_byte(fold_ref(w) ^ 8'($urandom_range(1, 255)));
            exp_pulses++;
            if (exp_err < 255) exp_err++;
        end
`else
        push_model(w);
`endif
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while (obs_w.size() < exp_w.size() && c < 500) begin
            @(negedge clk);
            c++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        byte_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_dest = 0;
        exp_err = 0;
        exp_pulses = 0;
        err_seen = 0;
        exp_w.delete(); exp_d.delete();
        obs_w.delete(); obs_d.delete();
    endtask

    task automatic test_reset();
        word_ready = 1'b0;
        do_reset();
        @(negedge clk);
        total++; if (byte_ready !== 1'b1) begin bad++; $display("FAIL reset_byte_ready got=%b want=1", byte_ready); end
        total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL reset_word_valid got=%b want=0", word_valid); end
        total++; if (word_out !== 32'd0) begin bad++; $display("FAIL reset_word_out got=%h want=0", word_out); end
        total++; if (dest_sel !== 4'd0) begin bad++; $display("FAIL reset_dest_sel got=%0d want=0", dest_sel); end
        total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL reset_err_cnt got=%0d want=0", err_cnt); end
        total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL reset_err_pulse got=%b want=0", err_pulse); end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        word_ready = 1'b1;
        send_frame(32'h1234_5678, 1'b1);
        @(negedge clk);
        total++; if (word_valid !== 1'b1) begin bad++; $display("FAIL single_latency_valid got=%b want=1", word_valid); end
        total++; if (word_out !== 32'h1234_5678) begin bad++; $display("FAIL single_word got=%h want=12345678", word_out); end
        total++; if (dest_sel !== 4'd0) begin bad++; $display("FAIL single_dest got=%0d want=0", dest_sel); end
        @(negedge clk);
        total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL single_valid_drop got=%b want=0", word_valid); end
        total++; if (dest_sel !== 4'd1) begin bad++; $display("FAIL single_dest_adv got=%0d want=1", dest_sel); end
        total++; if (word_out !== 32'h1234_5678) begin bad++; $display("FAIL single_word_hold got=%h want=12345678", word_out); end
        @(posedge clk); #1;
        wait_drain();
        total++; if (obs_w.size() != 1) begin bad++; $display("FAIL single_count got=%0d want=1", obs_w.size()); end
        obs_w.delete(); obs_d.delete(); exp_w.delete(); exp_d.delete();
    endtask

    task automatic test_back_to_back();
        do_reset();
        word_ready = 1'b1;
        for (int f = 0; f < 13; f++) send_frame($urandom, 1'b1);
        wait_drain();
        total++; if (obs_w.size() != exp_w.size()) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", obs_w.size(), exp_w.size()); end
        for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
            $display("b2b xfer %0d: word=%h dest=%0d", i, obs_w[i], obs_d[i]);
            total++;
            if (obs_w[i] !== exp_w[i] || obs_d[i] !== exp_d[i]) begin
                bad++;
                $display("FAIL b2b_word%0d got=%h/%0d want=%h/%0d", i, obs_w[i], obs_d[i], exp_w[i], exp_d[i]);
            end
        end
        total++; if (int'(dest_sel) !== exp_dest) begin bad++; $display("FAIL b2b_final_dest got=%0d want=%0d", dest_sel, exp_dest); end
        obs_w.delete(); obs_d.delete(); exp_w.delete(); exp_d.delete();
    endtask

`ifdef GRID_CHECK_EN
    task automatic test_check_error();
        logic [31:0] w;
        word_ready = 1'b1;
        w = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
        send_byte(8'h00);
        exp_pulses++;
        if (exp_err < 255) exp_err++;
        @(negedge clk);
        total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL chk_err_pulse got=%b want=1", err_pulse); end
        total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL chk_no_valid got=%b want=0", word_valid); end
        total++; if (int'(err_cnt) !== exp_err) begin bad++; $display("FAIL chk_err_cnt got=%0d want=%0d", err_cnt, exp_err); end
        @(negedge clk);
        total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL chk_pulse_width got=%b want=0", err_pulse); end
        total++; if (int'(dest_sel) !== exp_dest) begin bad++; $display("FAIL chk_dest_kept got=%0d want=%0d", dest_sel, exp_dest); end
        @(posedge clk); #1;
        for (int f = 0; f < 20; f++) send_frame($urandom, ($urandom_range(0, 2) != 0));
        for (int f = 0; f < 256; f++) send_frame($urandom, 1'b0);
        send_frame($urandom, 1'b1);
        wait_drain();
        total++; if (obs_w.size() != exp_w.size()) begin bad++; $display("FAIL mix_count got=%0d want=%0d", obs_w.size(), exp_w.size()); end
        for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
            $display("mix xfer %0d: word=%h dest=%0d", i, obs_w[i], obs_d[i]);
            total++;
            if (obs_w[i] !== exp_w[i] || obs_d[i] !== exp_d[i]) begin
                bad++;
                $display("FAIL mix_word%0d got=%h/%0d want=%h/%0d", i, obs_w[i], obs_d[i], exp_w[i], exp_d[i]);
            end
        end
        total++; if (int'(err_cnt) !== exp_err) begin bad++; $display("FAIL sat_err_cnt got=%0d want=%0d", err_cnt, exp_err); end
        total++; if (err_seen !== exp_pulses) begin bad++; $display("FAIL err_pulses got=%0d want=%0d", err_seen, exp_pulses); end
        total++; if (int'(dest_sel) !== exp_dest) begin bad++; $display("FAIL mix_final_dest got=%0d want=%0d", dest_sel, exp_dest); end
        obs_w.delete(); obs_d.delete(); exp_w.delete(); exp_d.delete();
    endtask
`endif

    task automatic test_backpressure();
        logic [31:0] w, w2;
        w  = $urandom;
        w2 = $urandom;
        word_ready = 1'b0;
        send_frame(w, 1'b1);
        // Offer the first byte of the next frame while the word is held.
        byte_in    = w2[31:24];
        byte_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (word_valid !== 1'b1 || word_out !== w || byte_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d got=v%b/%h/r%b want=v1/%h/r0", k, word_valid, word_out, byte_ready, w);
            end
        end
        @(posedge clk); #1;
        word_ready = 1'b1;
        @(negedge clk);
        total++; if (byte_ready !== 1'b0) begin bad++; $display("FAIL bp_xfer_cycle_ready got=%b want=0", byte_ready); end
        @(negedge clk);
        total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_drop got=%b want=0", word_valid); end
        total++; if (byte_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%b want=1", byte_ready); end
        @(posedge clk); #1;
        byte_valid = 1'b0;
        for (int i = 1; i < 4; i++) send_byte(w2[31-8*i -: 8]);
`ifdef GRID_CHECK_EN
        send_byte(fold_ref(w2));
`endif
        push_model(w2);
        wait_drain();
        total++; if (obs_w.size() != exp_w.size()) begin bad++; $display("FAIL bp_count got=%0d want=%0d", obs_w.size(), exp_w.size()); end
        for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
            $display("bp xfer %0d: word=%h dest=%0d", i, obs_w[i], obs_d[i]);
            total++;
            if (obs_w[i] !== exp_w[i] || obs_d[i] !== exp_d[i]) begin
                bad++;
                $display("FAIL bp_word%0d got=%h/%0d want=%h/%0d", i, obs_w[i], obs_d[i], exp_w[i], exp_d[i]);
            end
        end
        obs_w.delete(); obs_d.delete(); exp_w.delete(); exp_d.delete();
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        word_ready = 1'b1;
        send_frame($urandom, 1'b1);
        wait_drain();
        obs_w.delete(); obs_d.delete(); exp_w.delete(); exp_d.delete();
        // Reset while a word is held.
        word_ready = 1'b0;
        send_frame($urandom, 1'b1);
        do_reset();
        @(negedge clk);
        total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL rst_hold_valid got=%b want=0", word_valid); end
        total++; if (dest_sel !== 4'd0) begin bad++; $display("FAIL rst_hold_dest got=%0d want=0", dest_sel); end
        @(posedge clk); #1;
        // Reset after two bytes of a frame.
        word_ready = 1'b1;
        send_byte(8'hA5);
        send_byte(8'h5A);
        do_reset();
        @(negedge clk);
        total++; if (byte_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b want=1", byte_ready); end
        @(posedge clk); #1;
        w = $urandom;
        send_frame(w, 1'b1);
        wait_drain();
        total++; if (obs_w.size() != 1) begin bad++; $display("FAIL rst_mid_count got=%0d want=1", obs_w.size()); end
        if (obs_w.size() > 0) begin
            $display("rst xfer 0: word=%h dest=%0d", obs_w[0], obs_d[0]);
            total++;
            if (obs_w[0] !== w || obs_d[0] !== 0) begin
                bad++;
                $display("FAIL rst_mid_word got=%h/%0d want=%h/0", obs_w[0], obs_d[0], w);
            end
        end
        total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL rst_mid_err_cnt got=%0d want=0", err_cnt); end
        obs_w.delete(); obs_d.delete(); exp_w.delete(); exp_d.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
`ifdef GRID_CHECK_EN
        test_check_error();
`endif
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
